instr_fetch_unit: RTL and testbench

//  Multicycle MIPS fetch stage. Holds the PC, fetches one word from instruction memory over a req/ack

---
 rtl/mips_pkg.sv | 32 +++
 rtl/next_pc_calc.sv | 39 +++
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the multicycle MIPS fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_J       = 6'b000010;
    // Decodes to all-zero controls in the main controller.
    localparam logic [5:0] OP_INVALID = 6'b111111;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : mips_pkg

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC select: jump, taken branch, or pc + 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_unused_opcode;

    assign w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign w_branch_target = pc_plus4 + branch_offset(instr[15:0]);
    assign w_unused_opcode = &{1'b0, instr[31:26]};

    // Jump outranks a taken branch when the controller asserts both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (branch && zero) begin
            next_pc = w_branch_target;
        end
    end

endmodule : next_pc_calc

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multicycle MIPS fetch stage; req/ack imem fetch, hold, retire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic         r_req;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;

    assign w_pc_plus4 = r_pc + INSTR_BYTES;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (w_pc_plus4),
        .instr    (r_instr),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (w_next_pc)
    );

    // imem_req is registered so it is glitch-free and the address (r_pc)
    // cannot change while a request is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr_valid = r_valid;
    assign opcode      = r_valid ? r_instr[31:26] : OP_INVALID;

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit with directed fetch vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          ack_dly;
        int          rdy_dly;
        logic        br;
        logic        zr;
        logic        jp;
        logic        rst_mid;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_instr_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        jump;

    int errors = 0;
    int checks = 0;

    logic [31:0]  exp_addr_q[$];
    exp_instr_t   exp_instr_q[$];
    vec_t         vecs[$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr  = '0;
    logic [31:0] held_instr = '0;
    logic [31:0] held_pc    = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h expected no request", imem_addr);
                end else begin
                    check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
                end
                held_addr = imem_addr;
            end else if (imem_req && prev_req) begin
                check32("addr_stable", imem_addr, held_addr);
            end
            if (instr_valid && !prev_valid) begin
                if (exp_instr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got instr 0x%08h expected none", instr);
                end else begin
                    exp_instr_t e;
                    e = exp_instr_q.pop_front();
                    check32("instr", instr, e.instr);
                    check32("pc", pc, e.pc);
                    check32("pc_plus4", pc_plus4, e.pc + 32'd4);
                    check32("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
                end
                held_instr = instr;
                held_pc    = pc;
            end else if (instr_valid && prev_valid) begin
                check32("issue_instr_hold", instr, held_instr);
                check32("issue_pc_hold", pc, held_pc);
                check32("issue_no_req", {31'd0, imem_req}, 32'd0);
            end
            if (!instr_valid) begin
                check32("opcode_invalid", {26'd0, opcode}, 32'h3F);
            end
        end
        prev_req   = imem_req;
        prev_valid = instr_valid;
    end

    // ---------------- vector table ----------------
    task automatic add(input logic [31:0] a, input logic [31:0] d, input int ad, input int rd,
                       input logic b, input logic z, input logic j, input logic r);
        vec_t v;
        v.addr = a; v.rdata = d; v.ack_dly = ad; v.rdy_dly = rd;
        v.br = b; v.zr = z; v.jp = j; v.rst_mid = r;
        vecs.push_back(v);
    endtask

    task automatic reset_checks();
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_opcode", {26'd0, opcode}, 32'h3F);
        check32("rst_pc", pc, 32'h0000_0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lw; delayed-ack jump to 0x10; beq back to 0x04; j; beq not taken
        add(32'h0000_0000, 32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(32'h0000_0004, 32'h0800_0004, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(32'h0000_0010, 32'h1000_FFFC, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        add(32'h0000_0004, 32'h0800_0004, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(32'h0000_0010, 32'h1000_FFFC, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        // 0x18 - 0x1C wraps to 0xFFFF_FFFC, whose pc+4 wraps to 0
        add(32'h0000_0014, 32'h1000_FFF9, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(32'hFFFF_FFFC, 32'h0022_1820, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        // maximal forward branches climb 0x20000 per step into the 0x4 region
        for (int k = 0; k < 32'h2000; k++) begin
            add(32'(k) << 17, 32'h1000_7FFF, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        add(32'h4000_0000, 32'h1000_0007, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(32'h4000_0020, 32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(32'h4000_0400, 32'h8C01_0004, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(32'h0000_0000, 32'h0022_1820, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        check32("rst_instr", instr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            int   waited;
            v = vecs[i];
            exp_addr_q.push_back(v.addr);
            waited = 0;
            while (!imem_req && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!imem_req) begin
                checks++; errors++;
                $display("FAIL req_timeout: got no request expected addr 0x%08h", v.addr);
                break;
            end
            if (i == 0) check32("first_req_latency", 32'(waited), 32'd1);
            repeat (v.ack_dly) begin
                @(posedge clk); #1;
            end
            if (v.rst_mid) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                reset_checks();
                void'(exp_addr_q.size());
                rst_n = 1'b1;
                continue;
            end
            imem_ack = 1'b1; imem_rdata = v.rdata;
            exp_instr_q.push_back('{instr: v.rdata, pc: v.addr});
            @(posedge clk); #1;
            imem_ack = 1'b0; imem_rdata = 32'h0;
            check32("valid_after_ack", {31'd0, instr_valid}, 32'd1);
            for (int d = 0; d < v.rdy_dly; d++) begin
                imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
                branch = 1'b1; zero = 1'b1; jump = 1'b1;
                @(posedge clk); #1;
            end
            imem_ack = 1'b0;
            instr_ready = 1'b1; branch = v.br; zero = v.zr; jump = v.jp;
            @(posedge clk); #1;
            instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        end

        // final retire had no branch, so the following fetch is at 0x4
        exp_addr_q.push_back(32'h0000_0004);
        repeat (3) @(posedge clk);
        #1;
        check32("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        check32("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit

`default_nettype wire
